// File: rtl/muldiv_sequencer_pkg.sv
// Shared control types for the RV32M multiply/divide sequencer.
// Holds the op encoding (funct3), FSM states and the special-case quotient constants.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } MulDivOp;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } MulDivState;

    localparam logic [31:0] DIV0_QUOT = '1;
    localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

endpackage

// File: rtl/muldiv_engine.sv
// Radix-2 iterative engine: shift-add multiply or restoring divide, one bit per step.
// hi:lo is the product (multiply) or remainder:quotient (divide) register pair.
module muldiv_engine #(
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iLoad,
    input  logic             iStep,
    input  logic             iDiv,
    input  logic [WIDTH-1:0] iLoLoad,
    input  logic [WIDTH-1:0] iOpLoad,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo
);

    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        mulSum  = {1'b0, hi} + {1'b0, (lo[0] ? opnd : '0)};
        shifted = {hi, lo[WIDTH-1]};
        fits    = shifted >= {1'b0, opnd};
        // Remainder stays below the divisor, so the difference always fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - opnd;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (iLoad) begin
            hi   <= '0;
            lo   <= iLoLoad;
            opnd <= iOpLoad;
        end else if (iStep) begin
            if (iDiv) begin
                hi <= fits ? diff : shifted[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], fits};
            end else begin
                hi <= mulSum[WIDTH:1];
                lo <= {mulSum[0], lo[WIDTH-1:1]};
            end
        end
    end

    assign oHi = hi;
    assign oLo = lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle mul/div controller: FSM, sign handling, special cases and result mux.
// Optional MULDIV_EARLY_OUT_EN skips CALC for div-by-zero, overflow and zero multiply operands.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iFlush,
    output logic             oReady,
    output logic             oBusy,
    output logic             oValid,
    output logic [WIDTH-1:0] oResult
);

    MulDivState       state, nextState;
    MulDivOp          opReg;
    logic [WIDTH-1:0] aReg, bReg, pendReg, resultReg, fixResult;
    logic [CNT_W-1:0] cnt;
    logic             sA, sB, div0, ovf, mulZero;
    logic             isDiv, negA, negB, div0Now, ovfNow, mulZeroNow;
    logic [WIDTH-1:0] magA, magB, engHi, engLo, quot, rem;
    logic [2*WIDTH-1:0] prod;
    logic             engLoad, engStep;

    always_comb begin
        isDiv      = opReg[2];
        negA       = (opReg inside {MULH, MULHSU, DIV, REM}) && aReg[WIDTH-1];
        negB       = (opReg inside {MULH, DIV, REM}) && bReg[WIDTH-1];
        magA       = negA ? -aReg : aReg;
        magB       = negB ? -bReg : bReg;
        div0Now    = isDiv && (bReg == '0);
        ovfNow     = (opReg inside {DIV, REM}) && (aReg == OVF_QUOT) && (bReg == '1);
        mulZeroNow = !isDiv && ((aReg == '0) || (bReg == '0));
    end

    always_comb begin
        nextState = state;
        engLoad   = 1'b0;
        engStep   = 1'b0;
        case (state)
            IDLE: if (iStart) nextState = PREP;
            PREP: begin
                engLoad   = 1'b1;
                nextState = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                if (div0Now || ovfNow || mulZeroNow) nextState = FIX;
`endif
            end
            CALC: begin
                engStep = 1'b1;
                if (cnt == CNT_W'(1)) nextState = FIX;
            end
            FIX:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        // Flush aborts any op and also drops a start presented in IDLE.
        if (iFlush) nextState = IDLE;
    end

    muldiv_engine #(.WIDTH(WIDTH)) uEngine (
        .iClk    (iClk),
        .iRst    (iRst),
        .iLoad   (engLoad),
        .iStep   (engStep),
        .iDiv    (isDiv),
        .iLoLoad (isDiv ? magA : magB),
        .iOpLoad (isDiv ? magB : magA),
        .oHi     (engHi),
        .oLo     (engLo)
    );

    always_comb begin
        prod = {engHi, engLo};
        if (sA ^ sB) prod = -prod;
        quot = (sA ^ sB) ? -engLo : engLo;
        rem  = sA ? -engHi : engHi;
        case (opReg)
            MUL:               fixResult = prod[WIDTH-1:0];
            MULH, MULHSU, MULHU: fixResult = prod[2*WIDTH-1:WIDTH];
            DIV, DIVU:         fixResult = quot;
            default:           fixResult = rem;
        endcase
        if (mulZero) fixResult = '0;
        if (div0)    fixResult = opReg[1] ? aReg : DIV0_QUOT;
        if (ovf)     fixResult = opReg[1] ? '0 : OVF_QUOT;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            opReg     <= MUL;
            aReg      <= '0;
            bReg      <= '0;
            cnt       <= '0;
            sA        <= 1'b0;
            sB        <= 1'b0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            mulZero   <= 1'b0;
            pendReg   <= '0;
            resultReg <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && iStart && !iFlush) begin
                opReg <= MulDivOp'(iOp);
                aReg  <= iA;
                bReg  <= iB;
            end
            if (state == PREP) begin
                sA      <= negA;
                sB      <= negB;
                div0    <= div0Now;
                ovf     <= ovfNow;
                mulZero <= mulZeroNow;
                cnt     <= CNT_W'(WIDTH);
            end
            if (state == CALC) cnt <= cnt - CNT_W'(1);
            if (state == FIX) pendReg <= fixResult;
            if (oValid) resultReg <= pendReg;
        end
    end

    assign oReady  = (state == IDLE);
    assign oBusy   = (state != IDLE);
    // A flush or reset landing on DONE suppresses the pulse and leaves the old result visible.
    assign oValid  = (state == DONE) && !iFlush && !iRst;
    assign oResult = oValid ? pendReg : resultReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
// Honors MULDIV_EARLY_OUT_EN when computing expected latency.
module tb_muldiv_sequencer;

    logic        iClk, iRst, iStart, iFlush;
    logic [2:0]  iOp;
    logic [31:0] iA, iB;
    logic        oReady, oBusy, oValid;
    logic [31:0] oResult;
    int          nChecks = 0;
    int          nErr = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    muldiv_sequencer dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
        .iFlush(iFlush), .oReady(oReady), .oBusy(oBusy), .oValid(oValid), .oResult(oResult)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] up;
        bit          ovfCase;
        sa = a;
        sb = b;
        ovfCase = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovfCase ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovfCase ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (op[2] && b == 0) ||
                  ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                  (!op[2] && (a == 0 || b == 0));
        return (EARLY && special) ? 3 : 35;
    endfunction

    // Starts one op, waits for oValid, checks latency, result, hold behaviour and ready recovery.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, input string tag);
        logic [31:0] exp, prev;
        int          n;
        bit          held;
        exp  = refModel(op, a, b);
        prev = oResult;
        held = 1'b1;
        @(negedge iClk);
        chk({tag, "_rdy"}, {31'b0, oReady}, 32'd1);
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        @(posedge iClk); #1;
        iStart = 1'b0; iOp = 3'($urandom); iA = $urandom; iB = $urandom;
        n = 0;
        do begin
            @(posedge iClk); #1;
            n++;
            if (!oValid && oResult !== prev) held = 1'b0;
            iStart = noise && (n == 4 || n == 19);
            if (iStart) begin iOp = 3'($urandom); iA = $urandom; iB = $urandom; end
        end while (!oValid && n < 100);
        iStart = 1'b0;
        chk({tag, "_lat"}, 32'(n + 1), 32'(expLat(op, a, b)));
        chk({tag, "_res"}, oResult, exp);
        chk({tag, "_hold"}, {31'b0, held}, 32'd1);
        @(posedge iClk); #1;
        chk({tag, "_post"}, {29'b0, oValid, oReady, oBusy}, {29'b0, 3'b010});
        chk({tag, "_keep"}, oResult, exp);
    endtask

    initial begin
        logic [31:0] a, b, prev;
        bit          sawValid;
        iRst = 1'b1; iStart = 1'b0; iFlush = 1'b0; iOp = 3'd0; iA = '0; iB = '0;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_flags", {29'b0, oValid, oReady, oBusy}, {29'b0, 3'b010});
        chk("rst_res", oResult, 32'h0);
        @(negedge iClk); iRst = 1'b0;

        runOp(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul");
        runOp(3'd1, 32'd7, 32'hFFFF_FFFD, 1'b0, "mulh");
        runOp(3'd3, 32'd7, 32'hFFFF_FFFD, 1'b0, "mulhu");
        runOp(3'd2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, "mulhsu");
        runOp(3'd4, 32'hFFFF_FFEC, 32'd3, 1'b0, "div");
        runOp(3'd6, 32'hFFFF_FFEC, 32'd3, 1'b0, "rem");
        runOp(3'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, "divu");
        runOp(3'd5, 32'd5, 32'd0, 1'b0, "divu0");
        runOp(3'd6, 32'd5, 32'd0, 1'b0, "rem0");
        runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divovf");
        runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "removf");
        runOp(3'd0, 32'd0, 32'd9, 1'b0, "mulz");
        runOp(3'd5, 32'd100, 32'd7, 1'b1, "ignore");

        // Flush mid-CALC: no pulse, result unchanged, restart right away.
        prev = oResult;
        sawValid = 1'b0;
        @(negedge iClk);
        iStart = 1'b1; iOp = 3'd0; iA = 32'd3; iB = 32'd4;
        @(posedge iClk); #1; iStart = 1'b0;
        repeat (9) begin @(posedge iClk); #1; sawValid |= oValid; end
        iFlush = 1'b1;
        @(posedge iClk); #1;
        iFlush = 1'b0;
        chk("flush_busy", {31'b0, oBusy}, 32'd0);
        chk("flush_valid", {31'b0, sawValid | oValid}, 32'd0);
        chk("flush_res", oResult, prev);
        runOp(3'd0, 32'd11, 32'd13, 1'b0, "postflush");

        // Start coinciding with flush in IDLE is dropped.
        @(negedge iClk);
        iStart = 1'b1; iFlush = 1'b1; iOp = 3'd0; iA = 32'd2; iB = 32'd2;
        @(posedge iClk); #1;
        iStart = 1'b0; iFlush = 1'b0;
        chk("flushstart_busy", {31'b0, oBusy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                3: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            runOp(3'($urandom), a, b, 1'($urandom), "rnd");
        end

        // Reset mid-CALC after a nonzero result.
        runOp(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "prerst");
        sawValid = 1'b0;
        @(negedge iClk);
        iStart = 1'b1; iOp = 3'd0; iA = 32'd5; iB = 32'd9;
        @(posedge iClk); #1; iStart = 1'b0;
        repeat (16) @(posedge iClk);
        #1; iRst = 1'b1;
        @(posedge iClk); #1; iRst = 1'b0;
        chk("midrst_flags", {29'b0, oValid, oReady, oBusy}, {29'b0, 3'b010});
        chk("midrst_res", oResult, 32'h0);
        repeat (40) begin @(posedge iClk); #1; sawValid |= oValid; end
        chk("midrst_nopulse", {31'b0, sawValid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for RV32M multiply/divide/remainder ops. These are the ops the single-cycle ALU encode path cannot serve.
- Sits beside the main ALU in execute. Accepts one op from decode/control, holds the pipeline via oBusy, and returns one result with a single-cycle oValid pulse.
- Uses an iterative radix-2 engine: one bit per cycle, shift-add for multiply, restoring for divide.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  request; accepted only when oReady=1.
- iOp  input  3  MulDivOp (funct3): MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- iA  input  WIDTH  rs1 operand.
- iB  input  WIDTH  rs2 operand.
- iFlush  input  1  abort in-flight op (branch mispredict/trap).
- oReady  output  1  high in IDLE only.
- oBusy  output  1  high whenever not IDLE; stalls the pipeline.
- oValid  output  1  one-cycle pulse; oResult is valid in that cycle.
- oResult  output  WIDTH  result; held until the next oValid.

Behaviour:
- Reset:
  - state=IDLE; oReady=1; oBusy=0; oValid=0; oResult=0; all internal registers 0.
  - Reset wins over all other inputs, including when it arrives mid-operation.
- FSM states: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - On iStart, latch iOp/iA/iB and go to PREP.
  - With iStart=0, stay in IDLE.
- PREP (1 cycle):
  - Compute operand signs per op: MULH both signed, MULHSU A signed only, DIV/REM both signed, all others unsigned.
  - Take magnitudes and clear the accumulator.
  - Load counter = WIDTH.
  - Flag divide-by-zero (B==0) and signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF).
- CALC (exactly WIDTH cycles):
  - Multiply: 2*WIDTH-bit product register; add the multiplicand if LSB=1, then shift right.
  - Divide: shift the remainder:quotient pair left; subtract the divisor if no borrow and set the quotient LSB.
  - Counter decrements each cycle; exit to FIX when it reaches 1.
- FIX (1 cycle):
  - Apply sign correction: product negated if signs differ; quotient sign = sA^sB; remainder sign = sA.
  - Select the low half (MUL), high half (MULH*), quotient or remainder.
  - Special cases override the engine:
    - div-by-zero: DIV/DIVU -> all ones; REM/REMU -> A.
    - overflow: DIV -> 0x80000000; REM -> 0.
- DONE (1 cycle):
  - Register oResult; oValid=1; next state IDLE.
  - oReady returns to 1 the cycle after oValid.
- Latency: iStart accepted at cycle 0 -> oValid at cycle WIDTH+3 (35 for WIDTH=32). Fixed for every op and operand value.
- Back-to-back: iStart in the cycle right after oValid is accepted. Throughput is one op per WIDTH+4 cycles.
- iStart while oBusy is ignored; latched operands do not change.
- iFlush:
  - In any non-IDLE state: next state IDLE, no oValid, oResult keeps its previous value.
  - Flush and reset override DONE (no pulse).
  - iFlush with iStart in IDLE: the start is dropped.
- Arithmetic is exact two's complement. No X propagation: unused result bits are driven to 0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - PREP jumps directly to FIX (skips CALC) on divide-by-zero, signed overflow, or either multiply operand equal to 0.
  - Latency for those cases = 3 cycles (oValid at cycle 3). All other cases are unchanged.
- Undefined: latency is always WIDTH+3; the special cases are resolved only in FIX.

Decomposition:
- Shared control package (alongside the existing control typedefs):
  - MulDivOp enum (3-bit).
  - MulDivState enum (IDLE, PREP, CALC, FIX, DONE).
  - Constants DIV0_QUOT='1 and OVF_QUOT=32'h8000_0000.
- Decode extends its instruction subtypes with the M-extension case that drives iOp.
- One natural sub-module: muldiv_engine.
  - Holds the per-cycle shift/add/subtract step and the product/remainder registers.
  - Controlled by a step/load strobe from the muldiv_sequencer FSM, which owns the counter, sign flags and result mux.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> oValid at cycle 35, oResult=0xFFFFFFEB; MULH with the same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV A=-20, B=3 -> 0xFFFFFFFA; REM with the same operands -> 0xFFFFFFFE; DIVU A=0xFFFFFFFF, B=2 -> 0x7FFFFFFF.
- DIVU A=5, B=0 -> 0xFFFFFFFF; REM A=5, B=0 -> 5; DIV A=0x80000000, B=-1 -> 0x80000000; REM of the same -> 0. With MULDIV_EARLY_OUT_EN these arrive at cycle 3, otherwise at cycle 35.
- Start MUL, assert iFlush at cycle 10 -> oBusy=0 at cycle 11, no oValid, oResult unchanged. A new start at cycle 11 completes at cycle 46.
- Start DIVU 100/7; pulse iStart with different operands at cycles 5 and 20 -> both ignored; result=14. A new start in the cycle after oValid is accepted.
- Assert iRst at cycle 17 mid-CALC -> next cycle state IDLE, oBusy=0, oValid=0, oResult=0; no pulse ever appears.
